// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - word-serial sequencer feeding an external N-bit adder, carry chained across words
// Optional feature macro: ADD_SUB_EN (adds in_sub; subtract via inverted B and forced first-word carry-in)
module multiword_add_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_first,
  input  logic         in_last,
`ifdef ADD_SUB_EN
  input  logic         in_sub,
`endif
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_cout,
  output logic         out_last,
  output logic         err
);

  localparam int WCW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic           carry_q, carry_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           err_q, err_d;
  logic           sub_q, sub_d;

  // two-entry result FIFO, head selected by rd_ptr_q
  logic [N-1:0]   fsum_q  [2];
  logic           fcout_q [2];
  logic           flast_q [2];
  logic           rd_ptr_q, wr_ptr_q;
  logic [1:0]     count_q;

  logic           fire, pop;
  logic           first_eff, last_eff, sub_eff;
  logic [WCW-1:0] wcnt_eff;

`ifdef ADD_SUB_EN
  // operation mode is latched from the first word and held for the rest of the operand
  assign sub_eff = first_eff ? in_sub : sub_q;
`else
  assign sub_eff = 1'b0;
`endif

  // state register and per-operand context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      carry_q <= 1'b0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      sub_q   <= sub_d;
    end
  end

  // next state: chain words, close on in_last or the word-count limit, restart on a stray in_first
  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    sub_d   = sub_q;
    if (fire) begin
      sub_d = sub_eff;
      if ((state_q == S_RUN) && in_first) err_d = 1'b1;
      if (last_eff && !in_last)           err_d = 1'b1;
      if (last_eff) begin
        state_d = S_IDLE;
        carry_d = 1'b0;
        wcnt_d  = '0;
      end else begin
        state_d = S_RUN;
        carry_d = add_cout;
        wcnt_d  = wcnt_eff + 1'b1;
      end
    end
  end

  // outputs: adder drive, handshake and word classification
  always_comb begin
    out_valid = (count_q != 2'd0);
    pop       = out_valid & out_ready;
    in_ready  = rst_n & ((count_q < 2'd2) | pop);
    fire      = in_valid & in_ready;
    // a word opens a new operand when idle or when explicitly flagged as first
    first_eff = (state_q == S_IDLE) | in_first;
    wcnt_eff  = first_eff ? '0 : wcnt_q;
    last_eff  = in_last | (wcnt_eff == WCW'(WORDS - 1));
    add_a     = in_a;
    add_b     = sub_eff ? ~in_b : in_b;
    if (first_eff) add_cin = sub_eff ? 1'b1 : in_cin;
    else           add_cin = carry_q;
    out_sum   = fsum_q[rd_ptr_q];
    out_cout  = fcout_q[rd_ptr_q];
    out_last  = flast_q[rd_ptr_q];
    err       = err_q;
  end

  // result FIFO; push and pop may coincide when full since in_ready already allows it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fsum_q[i]  <= '0;
        fcout_q[i] <= 1'b0;
        flast_q[i] <= 1'b0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (fire) begin
        fsum_q[wr_ptr_q]  <= add_sum;
        fcout_q[wr_ptr_q] <= add_cout;
        flast_q[wr_ptr_q] <= last_eff;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({fire, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// tb/tb_multiword_add_seq.sv - scoreboard bench for multiword_add_seq with a behavioural adder
module tb_multiword_add_seq;
  localparam int N     = 8;
  localparam int WORDS = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic         in_cin = 1'b0, in_first = 1'b0, in_last = 1'b0, in_sub = 1'b0;
  logic [N-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid, out_ready = 1'b1;
  logic [N-1:0] out_sum;
  logic         out_cout, out_last, err;

  int n_cmp = 0;
  int n_bad = 0;

  // bench-side model of the operand chain
  logic [N+1:0] sb_q[$];
  logic         m_run = 1'b0, m_carry = 1'b0, m_sub = 1'b0, m_err = 1'b0;
  int           m_wcnt = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_first(in_first), .in_last(in_last),
`ifdef ADD_SUB_EN
    .in_sub(in_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .out_last(out_last), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model one accepted word and push its expected result
  task automatic model_word(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                            input logic first, input logic last, input logic sub);
    logic         fe, se, c, lst;
    logic [N-1:0] be;
    logic [N:0]   r;
    int           cnt;
    fe  = !m_run || first;
    se  = fe ? sub : m_sub;
`ifndef ADD_SUB_EN
    se  = 1'b0;
`endif
    be  = se ? ~b : b;
    c   = fe ? (se ? 1'b1 : cin) : m_carry;
    r   = {1'b0, a} + {1'b0, be} + {8'd0, c};
    cnt = fe ? 0 : m_wcnt;
    lst = last || (cnt == WORDS - 1);
    if (m_run && first) m_err = 1'b1;
    if (lst && !last)   m_err = 1'b1;
    sb_q.push_back({r[N-1:0], r[N], lst});
    m_sub = se;
    if (lst) begin
      m_run = 1'b0; m_carry = 1'b0; m_wcnt = 0;
    end else begin
      m_run = 1'b1; m_carry = r[N]; m_wcnt = cnt + 1;
    end
  endtask

  // present a word and hold it until accepted; called just after a rising edge
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                      input logic first, input logic last, input logic sub);
    bit done = 0;
    in_a = a; in_b = b; in_cin = cin; in_first = first; in_last = last; in_sub = sub;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model_word(a, b, cin, first, last, sub);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb_q.delete();
    m_run = 1'b0; m_carry = 1'b0; m_sub = 1'b0; m_err = 1'b0; m_wcnt = 0;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_cout",  32'(out_cout),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_err",       32'(err),       32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // scoreboard consumer: every handshaken result word is compared against the queue head
  initial begin
    logic [N+1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("out_sum",  32'(out_sum),  32'(e[N+1:2]));
          chk("out_cout", 32'(out_cout), 32'(e[1]));
          chk("out_last", 32'(out_last), 32'(e[0]));
        end
      end
    end
  end

  initial begin
    do_reset();

    // single word, latency one
    send(8'h05, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_lat_valid", 32'(out_valid), 32'd1);
    chk("t1_lat_sum",   32'(out_sum),   32'h0B);
    @(posedge clk); #1;
    drain();

    // two-word carry chain 01FF + 0001
    send(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // back-pressure: FIFO fills at two, head holds
    out_ready = 1'b0;
    send(8'h01, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0);
    send(8'h10, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
    in_a = 8'h7F; in_b = 8'h80; in_cin = 1'b1; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    chk("t3_hold_sum",      32'(out_sum),  32'h03);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_hold_sum2",     32'(out_sum),  32'h03);
    chk("t3_hold_valid",    32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h7F, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t3_err", 32'(err), 32'd0);

    // forced end after WORDS words without in_last
    send(8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'hF0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    chk("t4_err", 32'(err), 32'd1);
    // back in IDLE: a word without in_first is still a first word and takes in_cin
    send(8'h01, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    // reset mid-operand discards carry and FIFO
    out_ready = 1'b0;
    send(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_pending", 32'(out_valid), 32'd1);
    do_reset();
    @(negedge clk);
    chk("t5_valid_after_rst", 32'(out_valid), 32'd0);
    chk("t5_err_after_rst",   32'(err),       32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_no_carry", 32'(out_sum), 32'h01);
    @(posedge clk); #1;
    drain();

    // in_first while running restarts the chain with in_cin and flags err
    send(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h02, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t7_err", 32'(err), 32'd1);

    // random word stream
    do_reset();
    for (int i = 0; i < 24; i++)
      send(N'($urandom), N'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0), 1'b0);
    drain();
    chk("rand_err", 32'(err), 32'(m_err));

`ifdef ADD_SUB_EN
    do_reset();
    send(8'h05, 8'h06, 1'b0, 1'b1, 1'b1, 1'b1);
    send(8'h06, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1);
    send(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
